nibble_serial_adder: RTL and testbench
======================================

Name: nibble_serial_adder

Overview:
- Multi-cycle wide adder that feeds one 4-bit carry-lookahead adder slice, one nibble per clock.
- Accepts a WIDTH-bit operand pair plus carry-in through a valid/ready handshake and chains the slice carry between cycles.
- Returns the WIDTH-bit sum and carry-out through a valid/ready handshake.
- Sits between the operand source (register file or accumulator) and the result consumer; trades latency for area against a full-width adder.

Parameters:
- WIDTH, 16, operand and sum width in bits. Must be a multiple of 4 and at least 8.
- NIB, WIDTH/4 (derived localparam, not overridable), number of nibble steps.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  operand pair on A/B/Cin is valid.
- in_ready  out  1  block can accept operands.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- Cin  in  1  carry into bit 0.
- out_valid  out  1  Sum/Cout are valid.
- out_ready  in  1  consumer accepts the result.
- Sum  out  WIDTH  A+B+Cin modulo 2^WIDTH.
- Cout  out  1  carry out of bit WIDTH-1.
- V  out  1  signed overflow; present only with OVERFLOW_FLAG_EN.

Behaviour:
- Reset (rst high at a rising edge):
  - state=IDLE; in_ready=1; out_valid=0; Sum=0; Cout=0; V=0.
  - Internal operand registers, carry register and nibble counter all cleared.
- FSM states: IDLE, RUN, DONE. in_ready=1 only in IDLE; out_valid=1 only in DONE.
- IDLE:
  - On an edge with in_valid&&in_ready: latch A, B and Cin into the carry register; counter=0; go to RUN.
  - in_valid is ignored while in_ready=0.
- RUN, each edge:
  - Slice adds A[4i+3:4i] + B[4i+3:4i] + carry, where i=counter.
  - Slice sum is written to Sum[4i+3:4i]; slice carry-out goes to the carry register.
  - Counter increments. When i=NIB-1, Cout takes the slice carry-out and the state goes to DONE.
- Latency:
  - Acceptance at edge k gives out_valid=1 immediately after edge k+NIB.
  - WIDTH=16: 4 cycles after acceptance.
- DONE:
  - Sum, Cout and V are held stable while out_valid=1 && out_ready=0.
  - On an edge with out_ready=1: go to IDLE; out_valid=0. Sum and Cout keep their value; they are don't-care when out_valid=0.
- Throughput: one operation per NIB+2 cycles. No overlap; a new operand is never accepted in DONE, even when out_ready=1 on the same edge.
- Sum bits are not guaranteed valid while in RUN; consumers sample only on out_valid.
- Counter width: $clog2(NIB), minimum 1 bit. The counter never wraps within an operation.
- Reset mid-RUN or mid-DONE aborts the operation with no output handshake and returns to reset values on that edge.
- Input operands are sampled only at acceptance. Later changes to A/B/Cin have no effect.

Optional Feature:
- Macro: OVERFLOW_FLAG_EN.
- Defined:
  - Port V exists.
  - On the final RUN edge, V = slice carry-out XOR carry into bit WIDTH-1. The carry into bit WIDTH-1 equals A[WIDTH-1]^B[WIDTH-1]^Sum[WIDTH-1].
  - V is held with Sum in DONE and reset to 0.
- Undefined: port V and its logic are absent. All other behaviour is identical.

Test Plan (WIDTH=16):
- A=0x1234, B=0x4321, Cin=0, accepted at edge k -> out_valid rises after edge k+4; Sum=0x5555, Cout=0.
- A=0xFFFF, B=0x0001, Cin=0 -> Sum=0x0000, Cout=1 (carry ripples through all 4 nibbles). Then A=0xFFFF, B=0x0000, Cin=1 -> Sum=0x0000, Cout=1.
- With OVERFLOW_FLAG_EN:
  - A=0x7FFF, B=0x0001 -> Sum=0x8000, Cout=0, V=1.
  - A=0x8000, B=0x8000 -> Sum=0x0000, Cout=1, V=1.
  - A=0x0005, B=0xFFFE -> Sum=0x0003, Cout=1, V=0.
- Backpressure:
  - Hold out_ready=0 for 3 cycles after out_valid -> Sum/Cout stable, in_ready=0, a second in_valid is not accepted.
  - Set out_ready=1 -> IDLE next edge, in_ready=1.
- Reset mid-operation: assert rst at the 2nd RUN edge -> next edge in IDLE with all outputs at reset values; no out_valid pulse.
- Back-to-back: in_valid held high with two operand pairs and out_ready=1 -> second acceptance exactly 6 cycles after the first; both sums correct.

Source files
------------

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder that reuses one 4-bit carry-lookahead slice, one nibble per clock.
// Optional signed-overflow output V is built only when OVERFLOW_FLAG_EN is defined.
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
`ifdef OVERFLOW_FLAG_EN
  ,
  output logic             V
`endif
);

  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             carry_q, cout_q;
  logic             in_ready_q, out_valid_q;
  logic [CW-1:0]    cnt_q;
`ifdef OVERFLOW_FLAG_EN
  logic             v_q;
`endif

  // Bit offset of the nibble currently being added.
  logic [CW+1:0] nib_lsb;
  assign nib_lsb = {cnt_q, 2'b00};

  logic [3:0] slice_a, slice_b, g, p, c_d, sum_d;
  logic       cout_d, last_step;

  // Carry-lookahead slice: c_d[i] is the carry into bit i of the current nibble.
  // NOTE: every combinational output gets a value on every path, so no latches are inferred.
  always_comb begin
    slice_a = a_q[nib_lsb +: 4];
    slice_b = b_q[nib_lsb +: 4];
    g       = slice_a & slice_b;
    p       = slice_a ^ slice_b;
    c_d[0]  = carry_q;
    c_d[1]  = g[0] | (p[0] & carry_q);
    c_d[2]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry_q);
    c_d[3]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & carry_q);
    cout_d  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
            | (p[3] & p[2] & p[1] & p[0] & carry_q);
    sum_d   = p ^ c_d;
  end

  assign last_step = (cnt_q == CW'(NIB - 1));

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
      v_q         <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            a_q        <= A;
            b_q        <= B;
            carry_q    <= Cin;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          sum_q[nib_lsb +: 4] <= sum_d;
          carry_q             <= cout_d;
          if (last_step) begin
            // Counter is left at NIB-1 rather than wrapping; it is cleared on the next accept.
            cout_q      <= cout_d;
`ifdef OVERFLOW_FLAG_EN
            v_q         <= cout_d ^ c_d[3];
`endif
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign Sum       = sum_q;
  assign Cout      = cout_q;
`ifdef OVERFLOW_FLAG_EN
  assign V         = v_q;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed self-checking bench for nibble_serial_adder at WIDTH=16; V is checked when OVERFLOW_FLAG_EN is defined.
module tb_nibble_serial_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] A, B;
  logic        Cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] Sum;
  logic        Cout;
`ifdef OVERFLOW_FLAG_EN
  logic        V;
`endif

  int checks = 0;
  int errors = 0;

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Sum       (Sum),
    .Cout      (Cout)
`ifdef OVERFLOW_FLAG_EN
    ,
    .V         (V)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full operation from IDLE with latency checking; leaves the block back in IDLE.
  task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic [15:0] es, input logic ec, input logic ev);
    A = a; B = b; Cin = cin; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    check({tag, ":accepted"}, in_ready, 0);
    in_valid = 1'b0; A = ~a; B = ~b; Cin = ~cin;
    for (int i = 1; i < 4; i++) begin
      tick();
      check({tag, ":busy"}, out_valid, 0);
    end
    tick();
    check({tag, ":out_valid"}, out_valid, 1);
    check({tag, ":sum"}, Sum, es);
    check({tag, ":cout"}, Cout, ec);
`ifdef OVERFLOW_FLAG_EN
    check({tag, ":v"}, V, ev);
`endif
    out_ready = 1'b1;
    tick();
    check({tag, ":release_valid"}, out_valid, 0);
    check({tag, ":release_ready"}, in_ready, 1);
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; Cin = 1'b0;
    tick();
    tick();
    check("reset:in_ready", in_ready, 1);
    check("reset:out_valid", out_valid, 0);
    check("reset:sum", Sum, 0);
    check("reset:cout", Cout, 0);
`ifdef OVERFLOW_FLAG_EN
    check("reset:v", V, 0);
`endif
    rst = 1'b0;
    tick();

    do_op("basic",   16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    do_op("ripple",  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    do_op("cin",     16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
    do_op("posovf",  16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    do_op("mixsign", 16'h0005, 16'hFFFE, 1'b0, 16'h0003, 1'b1, 1'b0);
    do_op("alt",     16'hA5A5, 16'h5A5A, 1'b1, 16'h0000, 1'b1, 1'b0);

    // Backpressure: result held while out_ready is low, no new acceptance in DONE.
    A = 16'h0F0F; B = 16'h00F1; Cin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    check("bp:out_valid", out_valid, 1);
    check("bp:sum", Sum, 16'h1000);
    in_valid = 1'b1; A = 16'h1111; B = 16'h1111;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp:hold_valid", out_valid, 1);
      check("bp:hold_ready", in_ready, 0);
      check("bp:hold_sum", Sum, 16'h1000);
      check("bp:hold_cout", Cout, 0);
    end
    out_ready = 1'b1;
    tick();
    check("bp:release_valid", out_valid, 0);
    check("bp:no_accept_in_done", in_ready, 1);
    in_valid = 1'b0; out_ready = 1'b0;
    tick();
    check("bp:still_idle", in_ready, 1);

    // Leaves Cout=1 and V=1 so the mid-operation reset check below is meaningful.
    do_op("negovf", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

    // Reset asserted at the second RUN edge.
    A = 16'h1234; B = 16'h4321; Cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("midrst:in_ready", in_ready, 1);
    check("midrst:out_valid", out_valid, 0);
    check("midrst:sum", Sum, 0);
    check("midrst:cout", Cout, 0);
`ifdef OVERFLOW_FLAG_EN
    check("midrst:v", V, 0);
`endif
    rst = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("midrst:no_pulse", out_valid, 0);
      check("midrst:idle", in_ready, 1);
    end

    // Back-to-back: second acceptance exactly 6 edges after the first.
    A = 16'h1234; B = 16'h4321; Cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    check("b2b:first_accept", in_ready, 0);
    A = 16'hFFFF; B = 16'h0001; Cin = 1'b0;
    for (int j = 1; j <= 6; j++) begin
      tick();
      check("b2b:in_ready", in_ready, (j == 5) ? 1 : 0);
      check("b2b:out_valid", out_valid, (j == 4) ? 1 : 0);
      if (j == 4) begin
        check("b2b:sum1", Sum, 16'h5555);
        check("b2b:cout1", Cout, 0);
      end
    end
    in_valid = 1'b0;
    for (int j = 1; j <= 3; j++) begin
      tick();
      check("b2b:busy2", out_valid, 0);
    end
    tick();
    check("b2b:out_valid2", out_valid, 1);
    check("b2b:sum2", Sum, 16'h0000);
    check("b2b:cout2", Cout, 1);
    tick();
    check("b2b:release2", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
